// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared types for the icache read-burst responder
// Burst-length and beat-count types, ARSIZE codes, responder FSM states.
package axi_lite_pkg;
    typedef logic [7:0] burst_len_t;
    typedef logic [8:0] beat_cnt_t;
    localparam logic [2:0] ARSIZE_1B = 3'd0;
    localparam logic [2:0] ARSIZE_2B = 3'd1;
    localparam logic [2:0] ARSIZE_4B = 3'd2;
    typedef enum logic [1:0] {IDLE, WAIT, BURST} resp_state_e;
    function automatic beat_cnt_t beats_of(input burst_len_t len);
        return beat_cnt_t'(len) + 9'd1;
    endfunction
endpackage

// File: rtl/i_burst_read_responder_skid_buf.sv
// burst_skid_buf: 2-entry beat buffer with bypass, ordered head/tail storage
// Ports: clk, rst; in_valid/in_data (beat arriving from SRAM, no backpressure,
// caller guarantees space); out_valid/out_ready/out_data; count = stored beats.
module burst_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic         head_v_q, head_v_d, tail_v_q, tail_v_d;
    logic         pop;
    // An arriving beat is presented straight away when nothing is stored,
    // so the first beat leaves one cycle after its SRAM read.
    assign out_valid = head_v_q | in_valid;
    assign out_data  = head_v_q ? head_q : in_data;
    assign pop       = out_valid & out_ready;
    assign count     = {1'b0, head_v_q} + {1'b0, tail_v_q};
    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        tail_d   = tail_q;
        tail_v_d = tail_v_q;
        if (pop && head_v_q) begin
            head_d   = tail_q;
            head_v_d = tail_v_q;
            tail_v_d = 1'b0;
        end
        if (in_valid && !(pop && !head_v_q)) begin
            if (!head_v_d) begin
                head_d   = in_data;
                head_v_d = 1'b1;
            end else begin
                tail_d   = in_data;
                tail_v_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            head_v_q <= 1'b0;
            tail_v_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            head_v_q <= head_v_d;
            tail_v_q <= tail_v_d;
        end
    end
endmodule

// File: rtl/i_burst_read_responder.sv
// i_burst_read_responder: INCR read-burst slave fetching words from a sync-read SRAM
// Ports: clk, rst (sync, active-high); AR channel araddr/arlen/arsize/arvalid/arready;
// R channel rdata/rlast/rvalid/rready; SRAM port mem_en/mem_addr/mem_rdata (1-cycle read).
module i_burst_read_responder
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int FIRST_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);
    resp_state_e       state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    beat_cnt_t         issued_q, issued_d, total_q, total_d;
    logic              inflight_q, inflight_d, last_q, last_d;
    logic              buf_valid, buf_last, r_hs;
    logic [31:0]       buf_data;
    logic [1:0]        buf_cnt, occ;
    logic              unused;
    assign unused = ^{arsize, araddr[1:0], araddr[31:ADDR_W+2]};
    burst_skid_buf #(.W(33)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_data   ({last_q, mem_rdata}),
        .out_valid (buf_valid),
        .out_ready (rready),
        .out_data  ({buf_last, buf_data}),
        .count     (buf_cnt)
    );
    assign rvalid   = buf_valid & ~rst;
    assign rdata    = rvalid ? buf_data : '0;
    assign rlast    = rvalid & buf_last;
    assign r_hs     = rvalid & rready;
    assign arready  = state_q == IDLE;
    assign mem_addr = ptr_q;
    // Credit: beats read but not yet accepted, after this cycle's handshake.
    assign occ      = buf_cnt + {1'b0, inflight_q} - {1'b0, r_hs};
    assign mem_en   = !rst && state_q == BURST && issued_q != total_q && occ < 2'd2;
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ptr_d      = ptr_q;
        issued_d   = issued_q;
        total_d    = total_q;
        inflight_d = mem_en;
        last_d     = mem_en && issued_q == total_q - 9'd1;
        case (state_q)
            IDLE: if (arvalid) begin
                ptr_d    = araddr[ADDR_W+1:2];
                total_d  = beats_of(arlen);
                issued_d = '0;
                wait_d   = 4'(FIRST_LAT - 1);
                state_d  = (FIRST_LAT > 0) ? WAIT : BURST;
            end
            WAIT: begin
                wait_d  = wait_q - 4'd1;
                state_d = (wait_q == 4'd0) ? BURST : WAIT;
            end
            BURST: begin
                ptr_d    = mem_en ? ptr_q + 1'b1 : ptr_q;
                issued_d = mem_en ? issued_q + 9'd1 : issued_q;
                state_d  = (r_hs && rlast) ? IDLE : BURST;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            ptr_q      <= '0;
            issued_q   <= '0;
            total_q    <= '0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ptr_q      <= ptr_d;
            issued_q   <= issued_d;
            total_q    <= total_d;
            inflight_q <= inflight_d;
            last_q     <= last_d;
        end
    end
endmodule

// File: tb/tb_i_burst_read_responder.sv
// tb_i_burst_read_responder: scoreboard bench for two responder configurations
module tb_i_burst_read_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_cmp = 0, n_err = 0;
    logic        rst_a, arvalid_a, arready_a, rvalid_a, rlast_a, rready_a, mem_en_a;
    logic [31:0] araddr_a, rdata_a, mem_rdata_a;
    logic [7:0]  arlen_a;
    logic [11:0] mem_addr_a;
    logic        rst_b, arvalid_b, arready_b, rvalid_b, rlast_b, rready_b, mem_en_b;
    logic [31:0] araddr_b, rdata_b, mem_rdata_b;
    logic [7:0]  arlen_b;
    logic [3:0]  mem_addr_b;
    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [16];
    logic [32:0] qa[$], qb[$];
    int          qa_addr[$], qb_addr[$];
    int          occ_a = 0;
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [33:0] held_a, held_b;

    i_burst_read_responder #(.ADDR_W(12), .FIRST_LAT(0)) dut_a (
        .clk(clk), .rst(rst_a), .araddr(araddr_a), .arlen(arlen_a), .arsize(3'd2),
        .arvalid(arvalid_a), .arready(arready_a), .rdata(rdata_a), .rlast(rlast_a),
        .rvalid(rvalid_a), .rready(rready_a), .mem_en(mem_en_a), .mem_addr(mem_addr_a),
        .mem_rdata(mem_rdata_a));
    i_burst_read_responder #(.ADDR_W(4), .FIRST_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .araddr(araddr_b), .arlen(arlen_b), .arsize(3'd2),
        .arvalid(arvalid_b), .arready(arready_b), .rdata(rdata_b), .rlast(rlast_b),
        .rvalid(rvalid_b), .rready(rready_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
        .mem_rdata(mem_rdata_b));

    always @(posedge clk) begin
        if (mem_en_a) mem_rdata_a <= mem_a[mem_addr_a];
        if (mem_en_b) mem_rdata_b <= mem_b[mem_addr_b];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic bad(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (rst_a) begin
            occ_a   = 0;
            stall_a = 1'b0;
        end else begin
            if (mem_en_a) begin
                if (qa_addr.size() == 0) bad("extra_mem_en_a");
                else chk("mem_addr_a", 64'(mem_addr_a), 64'(qa_addr.pop_front()));
            end
            if (stall_a) chk("stall_hold_a", 64'({rvalid_a, rlast_a, rdata_a}), 64'(held_a));
            if (rvalid_a && rready_a) begin
                if (qa.size() == 0) bad("extra_beat_a");
                else chk("beat_a", 64'({rlast_a, rdata_a}), 64'(qa.pop_front()));
            end
            occ_a = occ_a + int'(mem_en_a) - int'(rvalid_a && rready_a);
            if (mem_en_a || rvalid_a) chk("outstanding_le2_a", 64'(occ_a > 2), 64'(0));
            stall_a = rvalid_a && !rready_a;
            held_a  = {rvalid_a, rlast_a, rdata_a};
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            stall_b = 1'b0;
        end else begin
            if (mem_en_b) begin
                if (qb_addr.size() == 0) bad("extra_mem_en_b");
                else chk("mem_addr_b", 64'(mem_addr_b), 64'(qb_addr.pop_front()));
            end
            if (stall_b) chk("stall_hold_b", 64'({rvalid_b, rlast_b, rdata_b}), 64'(held_b));
            if (rvalid_b && rready_b) begin
                if (qb.size() == 0) bad("extra_beat_b");
                else chk("beat_b", 64'({rlast_b, rdata_b}), 64'(qb.pop_front()));
            end
            stall_b = rvalid_b && !rready_b;
            held_b  = {rvalid_b, rlast_b, rdata_b};
        end
    end

    task automatic ar_a(input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        araddr_a = addr;
        arlen_a = len;
        arvalid_a = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            int w = (int'(addr >> 2) + i) % 4096;
            qa.push_back({i == int'(len), 32'(w * 3)});
            qa_addr.push_back(w);
        end
        while (!arready_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ar_accept_a", 64'(arready_a), 64'(1));
        @(posedge clk); #1;
        arvalid_a = 1'b0;
    endtask

    task automatic ar_b(input logic [31:0] addr, input logic [7:0] len, output int qsz, output int qprev);
        int n = 0;
        qprev = -1;
        araddr_b = addr;
        arlen_b = len;
        arvalid_b = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            int w = (int'(addr >> 2) + i) % 16;
            qb.push_back({i == int'(len), 32'(32'hA000 + w)});
            qb_addr.push_back(w);
        end
        while (!arready_b && n < 100) begin
            qprev = qb.size();
            @(posedge clk); #1;
            n++;
        end
        qsz = qb.size();
        chk("ar_accept_b", 64'(arready_b), 64'(1));
        @(posedge clk); #1;
        arvalid_b = 1'b0;
    endtask

    task automatic drain_a(input bit rnd);
        int n = 0;
        logic [3:0] pat = 4'b1001;
        while (qa.size() != 0 && n < 400) begin
            chk("arready_busy_a", 64'(arready_a), 64'(0));
            @(posedge clk); #1;
            rready_a = !rnd ? 1'b1 : (n < 4 ? pat[3-n] : 1'($urandom_range(0, 1)));
            n++;
        end
        rready_a = 1'b1;
        chk("drain_a", 64'(qa.size()), 64'(0));
        chk("arready_idle_a", 64'(arready_a), 64'(1));
    endtask

    task automatic drain_b();
        int n = 0;
        while (qb.size() != 0 && n < 400) begin
            chk("arready_busy_b", 64'(arready_b), 64'(0));
            @(posedge clk); #1;
            n++;
        end
        chk("drain_b", 64'(qb.size()), 64'(0));
        chk("arready_idle_b", 64'(arready_b), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, qs, qp;
        for (int w = 0; w < 4096; w++) mem_a[w] = 32'(w * 3);
        for (int w = 0; w < 16; w++) mem_b[w] = 32'hA000 + 32'(w);
        mem_rdata_a = '0;
        mem_rdata_b = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        arvalid_a = 1'b0; arvalid_b = 1'b0;
        araddr_a = '0; araddr_b = '0; arlen_a = '0; arlen_b = '0;
        rready_a = 1'b1; rready_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid_a", 64'(rvalid_a), 64'(0));
        chk("rst_rlast_a", 64'(rlast_a), 64'(0));
        chk("rst_rdata_a", 64'(rdata_a), 64'(0));
        chk("rst_mem_en_a", 64'(mem_en_a), 64'(0));
        chk("rst_rvalid_b", 64'(rvalid_b), 64'(0));
        chk("rst_mem_en_b", 64'(mem_en_b), 64'(0));
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        chk("arready_after_rst_a", 64'(arready_a), 64'(1));
        chk("arready_after_rst_b", 64'(arready_b), 64'(1));

        ar_a(32'h100, 8'd7);
        k = 0;
        while (!rvalid_a && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("first_rvalid_lat_a", 64'(k), 64'(1));
        drain_a(1'b0);

        ar_a(32'h7, 8'd0);
        drain_a(1'b0);

        ar_a(32'h200, 8'd7);
        drain_a(1'b1);

        ar_a(32'h0, 8'd7);
        k = 0;
        while (qa.size() > 6 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        rst_a = 1'b1;
        qa.delete();
        qa_addr.delete();
        @(posedge clk); #1;
        chk("rvalid_after_rst_a", 64'(rvalid_a), 64'(0));
        chk("mem_en_in_rst_a", 64'(mem_en_a), 64'(0));
        @(posedge clk); #1;
        rst_a = 1'b0;
        chk("arready_after_midrst_a", 64'(arready_a), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        ar_a(32'h40, 8'd3);
        drain_a(1'b0);

        ar_b(32'h3C, 8'd3, qs, qp);
        k = 0;
        while (!rvalid_b && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("first_rvalid_lat_b", 64'(k), 64'(4));
        drain_b();

        ar_b(32'h4, 8'd1, qs, qp);
        ar_b(32'h8, 8'd1, qs, qp);
        chk("held_ar_waits_idle_b", 64'(qs), 64'(2));
        chk("ar_cycle_after_last_b", 64'(qp), 64'(3));
        drain_b();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
